ysyx_25040101_iter_cmp_unit: RTL and testbench
==============================================

// Module: ysyx_25040101_iter_cmp_unit
// PURPOSE
//  Multi-cycle compare/branch-resolve unit. Computes a-b in CHUNK-bit slices per cycle (LSB first),
//  then derives eq/signed-less/unsigned-less to produce a branch-taken flag or an SLT/SLTU result.
//  Sits between ID/EX operand latch and PC-select/writeback; valid/ready on both sides, flushable.
// PARAMETERS
//  XLEN   32  operand/result width; must be a multiple of CHUNK
//  CHUNK   8  bits of subtraction resolved per cycle; NCHUNK = XLEN/CHUNK (CHUNK==XLEN -> 1 cycle)
// PORTS
//  clk_i          in   1     clock, rising edge
//  rst_n_i        in   1     async active-low reset
//  flush_i        in   1     sync abort of in-flight op (pipeline flush)
//  in_valid_i     in   1     operands/op valid
//  in_ready_o     out  1     unit can accept (state IDLE and ~flush_i)
//  a_i            in   XLEN  operand rs1
//  b_i            in   XLEN  operand rs2 / imm
//  op_i           in   4     {is_set, funct3}
//  out_valid_o    out  1     result valid (state DONE)
//  out_ready_i    in   1     consumer accepts result
//  taken_o        out  1     branch taken
//  result_o       out  XLEN  rd data
// BEHAVIOUR
//  Reset (async, rst_n_i=0): state IDLE, out_valid_o=0, taken_o=0, result_o=0, internal diff/carry/nz=0.
//   in_ready_o=1 during reset.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: accept on edge where in_valid_i & in_ready_o; latch a,b,op; diff=0, carry=1, nz=0, idx=0; -> CALC.
//  CALC: per cycle, slice k=idx: {c,s} = a[k] + ~b[k] + carry; diff[k]=s; carry=c; nz|=|s; idx++.
//   After slice NCHUNK-1 -> DONE. out_valid_o rises exactly NCHUNK cycles after the accept edge.
//  DONE flags (from final diff/carry/nz):
//   zero = ~nz; ult = ~carry (borrow);
//   ovf = (a[XLEN-1]^b[XLEN-1]) & (a[XLEN-1]^diff[XLEN-1]); slt = diff[XLEN-1]^ovf.
//  op decode:
//   is_set=0: funct3 000 BEQ taken=zero; 001 BNE ~zero; 100 BLT slt; 101 BGE ~slt;
//    110 BLTU ult; 111 BGEU ~ult; 010/011 taken=0. result_o=diff.
//   is_set=1: 010 SLT result={XLEN-1 zeros,slt}; 011 SLTU {zeros,ult}; other funct3 result=diff.
//    taken=0 always.
//  taken_o/result_o registered, updated on CALC->DONE edge; stable while out_valid_o & ~out_ready_i.
//  DONE: hold until out_ready_i; on out_valid_o & out_ready_i -> IDLE, out_valid_o=0 next cycle.
//   No accept in DONE (no same-cycle turnaround); next accept earliest the cycle after handoff.
//  flush_i (highest priority, any state): next state IDLE, out_valid_o=0, taken_o=0;
//   in_ready_o forced 0 that cycle, so no accept coincides with flush. result_o may keep stale value.
//  in_valid_i/a_i/b_i/op_i ignored outside IDLE; changes mid-CALC have no effect.
//  Async reset mid-CALC/DONE: immediate return to reset values; partial result discarded.
//  Wrap: a-b is modulo 2^XLEN; carry of last slice is the ~borrow.
// TESTING (XLEN=32, CHUNK=8 unless noted)
//  BLT a=0xFFFFFFFF b=0x00000001 -> out_valid 4 cycles after accept, taken=1, result=0xFFFFFFFE;
//   same with BLTU -> taken=0.
//  BLT a=0x80000000 b=0x00000001 (ovf) -> diff=0x7FFFFFFF, taken=1; BGE same operands -> taken=0.
//  SLTU a=0 b=1 -> result=0x00000001, taken=0; SLT a=5 b=5 -> result=0; BEQ a=b=0x12345678 -> taken=1,
//   result=0.
//  Backpressure: out_ready_i=0 for 3 cycles in DONE -> out_valid/taken/result held, in_ready_o=0;
//   release -> IDLE next cycle.
//  flush_i in 2nd CALC cycle -> no out_valid, in_ready_o=1 next cycle; new op then completes normally.
//  CHUNK=32: BNE a=1 b=2 -> out_valid 1 cycle after accept, taken=1; rst_n_i pulse in DONE -> all outputs 0.

Source files
------------

// File: rtl/ysyx_25040101_iter_cmp_unit.sv
// ysyx_25040101_iter_cmp_unit
//   Multi-cycle compare / branch-resolve unit. The difference a-b is formed
//   CHUNK bits per cycle, LSB slice first, with the carry rippling between
//   cycles. From the final difference, carry and non-zero flag it derives
//   eq / signed-less / unsigned-less. These produce a branch-taken flag or
//   an SLT/SLTU result.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   flush_i      synchronous abort of any in-flight operation
//   in_valid_i   operands/op valid        in_ready_o  unit idle and not flushing
//   a_i, b_i     operands (rs1, rs2/imm)  op_i        {is_set, funct3}
//   out_valid_o  result valid (DONE)      out_ready_i consumer accepts result
//   taken_o      branch taken             result_o    rd data
module ysyx_25040101_iter_cmp_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            taken_o,
    output logic [XLEN-1:0] result_o
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] diff;
    logic            carry;
    logic            nz;
    logic [IDX_W-1:0] idx;
    logic            out_valid_q;
    logic            taken_q;
    logic [XLEN-1:0] result_q;

    // Slice adder for the current chunk and the difference it produces.
    int unsigned     base;
    logic [CHUNK:0]  sum;
    logic [XLEN-1:0] diff_nx;
    logic            nz_nx;
    logic            last;

    // Turns the completed subtraction into {taken, result}.
    // A borrow out (carry=0) means a < b unsigned; the signed order is the
    // sign of the difference corrected by two's-complement overflow.
    function automatic logic [XLEN:0] resolve(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [XLEN-1:0] d,
        input logic            c,
        input logic            n
    );
        logic            zero;
        logic            ult;
        logic            ovf;
        logic            slt;
        logic            tk;
        logic [XLEN-1:0] res;
        zero = ~n;
        ult  = ~c;
        ovf  = (a[XLEN-1] ^ b[XLEN-1]) & (a[XLEN-1] ^ d[XLEN-1]);
        slt  = d[XLEN-1] ^ ovf;
        tk   = 1'b0;
        res  = d;
        if (op[3]) begin
            if (op[2:0] == 3'b010)      res = {{(XLEN-1){1'b0}}, slt};
            else if (op[2:0] == 3'b011) res = {{(XLEN-1){1'b0}}, ult};
        end else begin
            case (op[2:0])
                3'b000:  tk = zero;
                3'b001:  tk = ~zero;
                3'b100:  tk = slt;
                3'b101:  tk = ~slt;
                3'b110:  tk = ult;
                3'b111:  tk = ~ult;
                default: tk = 1'b0;
            endcase
        end
        return {tk, res};
    endfunction

    always_comb begin
        base    = 32'(idx) * 32'(CHUNK);
        sum     = {1'b0, a_q[base +: CHUNK]} + {1'b0, ~b_q[base +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
        diff_nx = diff;
        diff_nx[base +: CHUNK] = sum[CHUNK-1:0];
        nz_nx   = nz | (|sum[CHUNK-1:0]);
        last    = (idx == IDX_W'(NCHUNK - 1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            diff        <= '0;
            carry       <= 1'b0;
            nz          <= 1'b0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            result_q    <= '0;
        end else if (flush_i) begin
            // Abort wins over everything; result_q may keep a stale value.
            state       <= IDLE;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        op_q  <= op_i;
                        diff  <= '0;
                        carry <= 1'b1;   // +1 of the two's-complement negate
                        nz    <= 1'b0;
                        idx   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    diff  <= diff_nx;
                    carry <= sum[CHUNK];
                    nz    <= nz_nx;
                    if (last) begin
                        idx         <= '0;
                        {taken_q, result_q} <= resolve(op_q, a_q, b_q, diff_nx, sum[CHUNK], nz_nx);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // No accept here: the next op can start only after handoff.
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE) & ~flush_i;
    assign out_valid_o = out_valid_q;
    assign taken_o     = taken_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ysyx_25040101_iter_cmp_unit.sv
// Testbench for ysyx_25040101_iter_cmp_unit: an 8-bit-slice instance and a
// single-cycle (CHUNK=32) instance, scoreboard-checked against a plain
// arithmetic model of the compare/branch rules.
module tb_ysyx_25040101_iter_cmp_unit;

    typedef struct packed {
        logic        taken;
        logic [31:0] result;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [31:0] cyc = '0;

    logic        rst0, flush0, vld0, ird0, ov0, tk0, rdy0;
    logic [31:0] a0, b0, res0;
    logic [3:0]  op0;
    logic        rst1, flush1, vld1, ird1, ov1, tk1, rdy1;
    logic [31:0] a1, b1, res1;
    logic [3:0]  op1;

    logic        rand_rdy = 1'b0;
    logic        mrdy0 = 1'b1, mrdy1 = 1'b1;
    logic        rbit0 = 1'b1, rbit1 = 1'b1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic        seen[2];
    logic        cur_t[2];
    logic [31:0] cur_r[2];

    int          n_tests = 0;
    int          n_fail  = 0;

    assign rdy0 = rand_rdy ? rbit0 : mrdy0;
    assign rdy1 = rand_rdy ? rbit1 : mrdy1;

    ysyx_25040101_iter_cmp_unit #(.XLEN(32), .CHUNK(8)) u0 (
        .clk_i(clk), .rst_n_i(rst0), .flush_i(flush0), .in_valid_i(vld0),
        .in_ready_o(ird0), .a_i(a0), .b_i(b0), .op_i(op0),
        .out_valid_o(ov0), .out_ready_i(rdy0), .taken_o(tk0), .result_o(res0)
    );

    ysyx_25040101_iter_cmp_unit #(.XLEN(32), .CHUNK(32)) u1 (
        .clk_i(clk), .rst_n_i(rst1), .flush_i(flush1), .in_valid_i(vld1),
        .in_ready_o(ird1), .a_i(a1), .b_i(b1), .op_i(op1),
        .out_valid_o(ov1), .out_ready_i(rdy1), .taken_o(tk1), .result_o(res1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: comparisons straight from the instruction semantics.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        eq, lt, ltu, t;
        logic [31:0] r;
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        r   = a - b;
        t   = 1'b0;
        if (op[3]) begin
            if (op[2:0] == 3'b010)      r = {31'b0, lt};
            else if (op[2:0] == 3'b011) r = {31'b0, ltu};
        end else begin
            case (op[2:0])
                3'd0: t = eq;
                3'd1: t = !eq;
                3'd4: t = lt;
                3'd5: t = !lt;
                3'd6: t = ltu;
                3'd7: t = !ltu;
                default: t = 1'b0;
            endcase
        end
        return {t, r};
    endfunction

    task automatic mon(input int u, input logic v, input logic r, input logic t, input logic [31:0] res);
        exp_t e;
        if (v !== 1'b1) begin
            seen[u] = 1'b0;
            return;
        end
        if (!seen[u]) begin
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                chk("unexpected_valid", 32'(u), 32'hFFFF_FFFF);
                cur_t[u] = t;
                cur_r[u] = res;
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("latency_cycle", cyc, e.cyc);
                chk("taken", 32'(t), 32'(e.taken));
                chk("result", res, e.result);
                cur_t[u] = e.taken;
                cur_r[u] = e.result;
            end
            seen[u] = 1'b1;
        end else begin
            chk("hold_taken", 32'(t), 32'(cur_t[u]));
            chk("hold_result", res, cur_r[u]);
        end
        if (r) seen[u] = 1'b0;
    endtask

    always @(negedge clk) begin
        rbit0 = 1'($urandom);
        rbit1 = 1'($urandom);
        mon(0, ov0, rand_rdy ? rbit0 : mrdy0, tk0, res0);
        mon(1, ov1, rand_rdy ? rbit1 : mrdy1, tk1, res1);
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int u, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic t, input logic [31:0] r, input bit push);
        int   w;
        exp_t e;
        w = 0;
        while (((u == 0) ? ird0 : ird1) !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            chk("in_ready_timeout", 32'(u), 32'hFFFF_FFFF);
            return;
        end
        e.taken  = t;
        e.result = r;
        e.cyc    = cyc + 1 + ((u == 0) ? 4 : 1);
        if (u == 0) begin
            a0 = a; b0 = b; op0 = op; vld0 = 1'b1;
            if (push) q0.push_back(e);
        end else begin
            a1 = a; b1 = b; op1 = op; vld1 = 1'b1;
            if (push) q1.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble operands while busy; they must be ignored.
        if (u == 0) begin
            vld0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 4'($urandom);
        end else begin
            vld1 = 1'b0; a1 = $urandom; b1 = $urandom; op1 = 4'($urandom);
        end
    endtask

    task automatic rand_op(input int u);
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [32:0] m;
        int          mode;
        op   = 4'($urandom_range(0, 15));
        mode = $urandom_range(0, 3);
        a    = $urandom;
        case (mode)
            0:       b = a;
            1:       b = $urandom;
            2:       b = a ^ 32'h8000_0000;
            default: b = 32'($urandom_range(0, 3));
        endcase
        m = model(op, a, b);
        issue(u, op, a, b, m[32], m[31:0], 1'b1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov0 || ov1) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        t;
        logic [31:0] r;
    } dir_t;

    dir_t dirs[9] = '{
        '{4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE},  // BLT
        '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE},  // BLTU
        '{4'b0100, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF},  // BLT ovf
        '{4'b0101, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF},  // BGE ovf
        '{4'b1011, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001},  // SLTU
        '{4'b1010, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000},  // SLT
        '{4'b0000, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000},  // BEQ
        '{4'b0010, 32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0002},  // branch 010
        '{4'b1000, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE}   // set, other
    };

    initial begin
        int w;
        rst0 = 1'b0; rst1 = 1'b0;
        flush0 = 1'b0; flush1 = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0;
        a1 = '0; b1 = '0; op1 = '0;
        seen[0] = 1'b0; seen[1] = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_taken", 32'(tk0), 32'd0);
        chk("rst_result", res0, 32'd0);
        chk("rst_in_ready", 32'(ird0), 32'd1);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            issue(0, dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].t, dirs[i].r, 1'b1);
        drain();

        // Backpressure: hold DONE for three cycles.
        mrdy0 = 1'b0;
        issue(0, 4'b0100, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        w = 0;
        while (!ov0 && w < 20) begin @(negedge clk); w++; end
        chk("bp_valid_seen", 32'(ov0), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(ird0), 32'd0);
            chk("bp_out_valid", 32'(ov0), 32'd1);
        end
        mrdy0 = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(ov0), 32'd0);
        chk("bp_release_ready", 32'(ird0), 32'd1);

        // Flush during the second CALC cycle.
        issue(0, 4'b0000, 32'h1, 32'h1, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        flush0 = 1'b1;
        #1;
        chk("flush_in_ready", 32'(ird0), 32'd0);
        @(negedge clk);
        flush0 = 1'b0;
        #1;
        chk("post_flush_ready", 32'(ird0), 32'd1);
        chk("post_flush_valid", 32'(ov0), 32'd0);
        @(negedge clk);
        issue(0, 4'b0001, 32'h7, 32'h9, 1'b1, 32'hFFFF_FFFE, 1'b1);
        drain();

        // Random ops with random consumer backpressure on both units.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) rand_op(0);
        for (int i = 0; i < 20; i++) rand_op(1);
        drain();
        rand_rdy = 1'b0;
        @(negedge clk);

        // Single-cycle instance: latency 1, then reset while in DONE.
        mrdy1 = 1'b0;
        issue(1, 4'b0001, 32'h1, 32'h2, 1'b1, 32'hFFFF_FFFF, 1'b1);
        w = 0;
        while (!ov1 && w < 20) begin @(negedge clk); w++; end
        chk("c32_valid_seen", 32'(ov1), 32'd1);
        #2 rst1 = 1'b0;
        #1;
        chk("c32_rst_valid", 32'(ov1), 32'd0);
        chk("c32_rst_taken", 32'(tk1), 32'd0);
        chk("c32_rst_result", res1, 32'd0);
        chk("c32_rst_ready", 32'(ird1), 32'd1);
        @(negedge clk);
        rst1 = 1'b1;
        mrdy1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) rand_op(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
